// File: rtl/uart_rx_fifo.sv
// UART receiver: majority-filtered line, framing FSM, show-ahead receive FIFO, sticky errors.
// Latency: a word shows on rx_valid/rx_data/rx_count one enabled cycle after its stop-bit sample.
// Backpressure: none on the line side; a push into a full FIFO with no pop drops the word and sets overrun_err.
//
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit to each frame and enables parity_err).
//
// Ports:
//   clk, reset       single rising-edge clock, asynchronous active-high reset
//   ena              clock enable; low freezes every register
//   rx_signal        serial line, idle high, LSB first
//   baud_div         clocks per bit (values below 4 act as 4), captured at frame start
//   parity_odd       1 = odd parity, 0 = even (ignored without UART_RX_PARITY_EN)
//   rx_data/rx_valid FIFO head (show-ahead, 0 when empty) and not-empty flag
//   rx_ready         consumer pop request, honoured only when rx_valid
//   rx_count         FIFO occupancy, 0..FIFO_DEPTH
//   frame_err, parity_err, overrun_err  sticky error flags
//   err_clear        clears the sticky flags; an error event in the same cycle wins
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ena,
  input  logic                        rx_signal,
  input  logic [DIV_WIDTH-1:0]        baud_div,
  input  logic                        parity_odd,
  output logic [DATA_WIDTH-1:0]       rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun_err,
  input  logic                        err_clear
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(DATA_WIDTH + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Input filter
  logic [2:0] sync_q, sync_d;
  logic       filt_q, filt_d;

  // Framing FSM
  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  stop_done_q, stop_done_d;
  logic [DIV_WIDTH-1:0]  div_eff;
  logic                  push_req;
  logic                  frame_evt;

  // FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, pop, do_push, overrun_evt;

  // Sticky errors
  logic frame_err_q, frame_err_d;
  logic overrun_err_q, overrun_err_d;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_evt;
  logic parity_err_q, parity_err_d;
`else
  // parity_odd has no function in this build
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // Shift-register filter: the majority of the last three samples is registered, so a
  // single-cycle glitch never reaches the FSM.
  always_comb begin
    sync_d = {sync_q[1:0], rx_signal};
    filt_d = (sync_q[0] & sync_q[1]) | (sync_q[0] & sync_q[2]) | (sync_q[1] & sync_q[2]);
  end

  assign div_eff = (baud_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : baud_div;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    stop_done_d = stop_done_q;
    push_req    = 1'b0;
    frame_evt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    parity_evt  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        bit_cnt_d   = '0;
        stop_done_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = 1'b0;
`endif
        if (!filt_q) begin
          // Divisor is frozen here for the whole frame; first sample lands mid start bit.
          state_d = S_START;
          div_d   = div_eff;
          cnt_d   = (div_eff >> 1) - DIV_WIDTH'(1);
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!filt_q) begin
            state_d = S_DATA;
            cnt_d   = div_q - DIV_WIDTH'(1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d   = {filt_q, shift_q[DATA_WIDTH-1:1]};
          cnt_d     = div_q - DIV_WIDTH'(1);
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          // XOR of data and parity bit is 0 for even parity, 1 for odd.
          par_bad_d = ((^shift_q) ^ filt_q) != parity_odd;
          cnt_d     = div_q - DIV_WIDTH'(1);
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
`endif
      S_STOP: begin
        if (stop_done_q) begin
          // Bad stop already reported; a break holds here until the line goes high.
          if (filt_q) state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          if (filt_q) begin
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) parity_evt = 1'b1;
            else           push_req   = 1'b1;
`else
            push_req = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            frame_evt   = 1'b1;
            stop_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: a push into a full FIFO is accepted only when a pop frees the slot the same cycle.
  always_comb begin
    full        = (count_q == CW'(FIFO_DEPTH));
    pop         = rx_valid && rx_ready;
    do_push     = push_req && (!full || pop);
    overrun_evt = push_req && full && !pop;
    mem_d       = mem_q;
    if (do_push) mem_d[wr_ptr_q] = shift_q;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    frame_err_d   = (err_clear ? 1'b0 : frame_err_q) | frame_evt;
    overrun_err_d = (err_clear ? 1'b0 : overrun_err_q) | overrun_evt;
`ifdef UART_RX_PARITY_EN
    parity_err_d  = (err_clear ? 1'b0 : parity_err_q) | parity_evt;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= 3'b111;
      filt_q        <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      div_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      stop_done_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else if (ena) begin
      sync_q        <= sync_d;
      filt_q        <= filt_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      stop_done_q   <= stop_done_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_valid    = (count_q != '0);
  assign rx_data     = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign rx_count    = count_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DATA_WIDTH=8, FIFO_DEPTH=4, baud_div=8).
// Expected words go into a queue as frames are driven and are popped when the DUT presents them.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       rx_signal;
  logic [15:0] baud_div;
  logic       parity_odd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] rx_count;
  logic       frame_err, parity_err, overrun_err;
  logic       err_clear;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  logic       exp_frm = 1'b0;
  logic       exp_par = 1'b0;

  uart_rx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .rx_signal   (rx_signal),
    .baud_div    (baud_div),
    .parity_odd  (parity_odd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_count    (rx_count),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_status(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check({tag, "_count"}, 32'(rx_count), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
    check({tag, "_data"},  32'(rx_data),  32'(head));
    check({tag, "_ovr"},   32'(overrun_err), 32'(exp_ovr));
    check({tag, "_frm"},   32'(frame_err),   32'(exp_frm));
    check({tag, "_par"},   32'(parity_err),  32'(exp_par));
  endtask

  task automatic drive_bit(input logic b);
    rx_signal = b;
    repeat (8) @(negedge clk);
  endtask

  // Drives one frame; par_flip inverts the correct parity bit (parity builds only).
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    logic par_bit;
    logic good;
    par_bit = (^d) ^ parity_odd ^ par_flip;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
    good = !par_flip;
`else
    good = 1'b1;
`endif
    drive_bit(stop_bit);
    if (!stop_bit)         exp_frm = 1'b1;
    else if (!good)        exp_par = 1'b1;
    else if (exp_q.size() < 4) exp_q.push_back(d);
    else                   exp_ovr = 1'b1;
    rx_signal = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] e;
    check({tag, "_pvalid"}, 32'(rx_valid), 32'(1));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    check({tag, "_pdata"}, 32'(rx_data), 32'(e));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    exp_ovr = 1'b0;
    exp_frm = 1'b0;
    exp_par = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    reset      = 1'b1;
    ena        = 1'b1;
    rx_signal  = 1'b1;
    baud_div   = 16'd8;
    parity_odd = 1'b0;
    rx_ready   = 1'b0;
    err_clear  = 1'b0;
    repeat (3) @(negedge clk);
    check_status("rst");
    reset = 1'b0;
    repeat (16) @(negedge clk);

    // Pop request on an empty FIFO does nothing
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rx_ready = 1'b0;
    check_status("empty_pop");

    // Single word
    send_frame(8'hA5, 1'b1, 1'b0);
    check_status("a5");
    pop_one("a5");
    check_status("a5_after");

    // Fill past depth: fifth word dropped, overrun set
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    check_status("ovr");
    // ena low freezes the FIFO even with rx_ready high
    ena = 1'b0;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    ena = 1'b1;
    check_status("freeze");
    for (int i = 0; i < 4; i++) pop_one("ovr_pop");
    check_status("ovr_drained");
    clear_errors();
    check_status("ovr_clr");

    // Bad stop bit, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0);
    check_status("frm");
    send_frame(8'h55, 1'b1, 1'b0);
    check_status("frm_55");
    pop_one("frm_55");
    clear_errors();
    check_status("frm_clr");

    // One-clock glitch is filtered out
    rx_signal = 1'b0;
    @(negedge clk);
    rx_signal = 1'b1;
    repeat (20) @(negedge clk);
    check_status("glitch");
    // Three-clock pulse is a rejected false start
    rx_signal = 1'b0;
    repeat (3) @(negedge clk);
    rx_signal = 1'b1;
    repeat (30) @(negedge clk);
    check_status("pulse");
    send_frame(8'h96, 1'b1, 1'b0);
    check_status("after_pulse");
    pop_one("after_pulse");

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    check_status("par_bad");
    send_frame(8'h07, 1'b1, 1'b0);
    check_status("par_good");
    pop_one("par_good");
    parity_odd = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    pop_one("par_odd");
    clear_errors();
    parity_odd = 1'b0;
    check_status("par_clr");
`endif

    // Reset in the middle of 0x5A with a word already queued and an error pending
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    check_status("pre_rst");
    v = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v[i]);
    rx_signal = v[4];
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_frm = 1'b0;
    exp_par = 1'b0;
    check_status("rst_mid");
    @(negedge clk);
    rx_signal = 1'b1;
    reset = 1'b0;
    repeat (16) @(negedge clk);
    check_status("rst_rel");
    send_frame(8'hC3, 1'b1, 1'b0);
    check_status("c3");
    pop_one("c3");
    check_status("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
